// File: rtl/prefix_subtractor_pipe.sv
// Pipelined Sklansky prefix subtractor: diff = a + ~b + 1, one prefix level per stage.
// Optional status flags (zero/negative/overflow) enabled by defining PREFIX_SUB_FLAGS_EN.
module prefix_subtractor_pipe #(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 2**LEVELS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef PREFIX_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             overflow
`endif
);

    // S0..S_LEVELS carry g/p/x; column 0 is the carry-in, column c is bit c-1
    localparam int NS = LEVELS + 1;

    logic [NS-1:0]    v_q;
    logic [WIDTH:0]   g_q [NS];
    logic [WIDTH:0]   p_q [NS];
    logic [WIDTH-1:0] x_q [NS];
`ifdef PREFIX_SUB_FLAGS_EN
    logic [NS-1:0]    am_q;
    logic [NS-1:0]    bm_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             ovf_d;
`endif

    logic             vo_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_d;

    logic [NS-1:0]    adv;
    logic             advo;
    logic             acc;
    logic [WIDTH:0]   lg [LEVELS];
    logic [WIDTH:0]   lp [LEVELS];
    logic             unused_p;

    // Ready chain from the consumer back to the operand source
    always_comb begin
        logic rdy;
        advo = vo_q & out_ready;
        rdy  = ~vo_q | out_ready;
        adv  = '0;
        for (int n = NS - 1; n >= 0; n--) begin
            adv[n] = v_q[n] & rdy;
            rdy    = ~v_q[n] | rdy;
        end
        in_ready = rdy;
    end

    assign acc = in_valid & in_ready;

    // Sklansky level k+1: odd blocks of size 2**k absorb the block below
    always_comb begin
        for (int k = 0; k < LEVELS; k++) begin
            lg[k] = g_q[k];
            lp[k] = p_q[k];
            for (int j = 0; j < WIDTH; j++) begin
                if (((j >> k) & 1) == 1) begin
                    lg[k][j] = g_q[k][j]
                             | (p_q[k][j] & g_q[k][((j >> k) << k) - 1]);
                    lp[k][j] = p_q[k][j] & p_q[k][((j >> k) << k) - 1];
                end
            end
        end
    end

    // Final sum: carries into bits 0..W-1 are the prefix generates
    always_comb begin
        diff_d   = x_q[LEVELS] ^ g_q[LEVELS][WIDTH-1:0];
        borrow_d = ~(g_q[LEVELS][WIDTH]
                   | (p_q[LEVELS][WIDTH] & g_q[LEVELS][WIDTH-1]));
`ifdef PREFIX_SUB_FLAGS_EN
        ovf_d    = (am_q[LEVELS] != bm_q[LEVELS])
                 && (diff_d[WIDTH-1] != am_q[LEVELS]);
`endif
    end

    assign unused_p = ^p_q[LEVELS][WIDTH-1:0];

    // Prefix stages: load on upstream transfer, empty when drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int n = 0; n < NS; n++) begin
                g_q[n] <= '0;
                p_q[n] <= '0;
                x_q[n] <= '0;
            end
`ifdef PREFIX_SUB_FLAGS_EN
            am_q <= '0;
            bm_q <= '0;
`endif
        end else begin
            if (acc) begin
                v_q[0] <= 1'b1;
                g_q[0] <= {a & ~b, 1'b1};
                p_q[0] <= {a | ~b, 1'b1};
                x_q[0] <= a ^ ~b;
`ifdef PREFIX_SUB_FLAGS_EN
                am_q[0] <= a[WIDTH-1];
                bm_q[0] <= b[WIDTH-1];
`endif
            end else if (adv[0]) begin
                v_q[0] <= 1'b0;
            end
            for (int n = 1; n < NS; n++) begin
                if (adv[n-1]) begin
                    v_q[n] <= 1'b1;
                    g_q[n] <= lg[n-1];
                    p_q[n] <= lp[n-1];
                    x_q[n] <= x_q[n-1];
`ifdef PREFIX_SUB_FLAGS_EN
                    am_q[n] <= am_q[n-1];
                    bm_q[n] <= bm_q[n-1];
`endif
                end else if (adv[n]) begin
                    v_q[n] <= 1'b0;
                end
            end
        end
    end

    // Output register: holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vo_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef PREFIX_SUB_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else if (adv[NS-1]) begin
            vo_q     <= 1'b1;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef PREFIX_SUB_FLAGS_EN
            zero_q   <= (diff_d == '0);
            neg_q    <= diff_d[WIDTH-1];
            ovf_q    <= ovf_d;
`endif
        end else if (advo) begin
            vo_q <= 1'b0;
        end
    end

    assign out_valid  = vo_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef PREFIX_SUB_FLAGS_EN
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Directed + scoreboard bench for prefix_subtractor_pipe (LEVELS=3).
// Flag checks are active when PREFIX_SUB_FLAGS_EN is defined.
module tb_prefix_subtractor_pipe;

    localparam int LV = 3;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef PREFIX_SUB_FLAGS_EN
    logic         zero;
    logic         negative;
    logic         overflow;
`endif

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int emit_cnt = 0;
    logic [11:0] sbq [$];

    prefix_subtractor_pipe #(.LEVELS(LV), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out)
`ifdef PREFIX_SUB_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [7:0] x,
                                          input logic [7:0] y);
        logic [8:0] d;
        d = {1'b0, x} - {1'b0, y};
`ifdef PREFIX_SUB_FLAGS_EN
        return {(x[7] != y[7]) && (d[7] != x[7]), d[7], d[7:0] == 8'h00,
                d[8], d[7:0]};
`else
        return {3'b000, d[8], d[7:0]};
`endif
    endfunction

    function automatic logic [11:0] obs_pack();
`ifdef PREFIX_SUB_FLAGS_EN
        return {overflow, negative, zero, borrow_out, diff};
`else
        return {3'b000, borrow_out, diff};
`endif
    endfunction

    // Scoreboard: handshakes sampled mid-cycle, ahead of the edge that commits them
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                emit_cnt++;
                if (sbq.size() == 0) check("spurious", 1, 0);
                else check("sb", obs_pack(), sbq.pop_front());
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                sbq.push_back(model(a, b));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] ed,
                          input logic eb, input logic [2:0] ef);
        in_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        in_valid = 1'b0;
        repeat (3) begin
            tick();
            check({tag, "_early"}, out_valid, 0);
        end
        tick();
        check({tag, "_v"}, out_valid, 1);
        check({tag, "_d"}, diff, ed);
        check({tag, "_b"}, borrow_out, eb);
`ifdef PREFIX_SUB_FLAGS_EN
        check({tag, "_f"}, {overflow, negative, zero}, ef);
`else
        if (ef === 3'bxxx) $display("unused");
`endif
        tick();
        check({tag, "_once"}, out_valid, 0);
    endtask

    logic [7:0] a_t [8] = '{8'h10, 8'h20, 8'h30, 8'h40,
                            8'h50, 8'h60, 8'h70, 8'h80};
    logic [7:0] b_t [8] = '{8'h01, 8'h05, 8'h40, 8'h3F,
                            8'h50, 8'h7F, 8'h00, 8'h90};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  idx;
        logic acc;

        repeat (2) tick();
        check("rst_ov", out_valid, 0);
        rst = 1'b0;
        #1;
        check("rst_rdy", in_ready, 1);
        check("rst_d", diff, 0);
        check("rst_b", borrow_out, 0);

        single("s53", 8'h05, 8'h03, 8'h02, 1'b0, 3'b000);
        single("s35", 8'h03, 8'h05, 8'hFE, 1'b1, 3'b010);

        // back-to-back: signed overflow then zero result
        in_valid = 1'b1;
        a = 8'h80;
        b = 8'h01;
        tick();
        a = 8'h00;
        b = 8'h00;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        tick();
        check("bb1_v", out_valid, 1);
        check("bb1_d", diff, 8'h7F);
        check("bb1_b", borrow_out, 0);
`ifdef PREFIX_SUB_FLAGS_EN
        check("bb1_f", {overflow, negative, zero}, 3'b100);
`endif
        tick();
        check("bb2_v", out_valid, 1);
        check("bb2_d", diff, 8'h00);
        check("bb2_b", borrow_out, 0);
`ifdef PREFIX_SUB_FLAGS_EN
        check("bb2_f", {overflow, negative, zero}, 3'b001);
`endif
        tick();
        check("bb_end", out_valid, 0);

        // stalled consumer: pipe fills after 5 accepts, head result holds
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        a = a_t[0];
        b = b_t[0];
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                check("stall_rdy", in_ready, idx < 5);
                a = a_t[idx];
                b = b_t[idx];
            end
        end
        check("stall_acc", idx, 5);
        repeat (3) begin
            tick();
            check("hold_v", out_valid, 1);
            check("hold_d", diff, 8'h0F);
            check("hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            check("drain_v", out_valid, 1);
            tick();
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    a = a_t[idx];
                    b = b_t[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("drain_acc", idx, 8);
        @(negedge clk);
        check("drain_end", out_valid, 0);

        // asynchronous reset with three results in flight
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 8'(9 + i);
            b = 8'h02;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("pre_rst_v", out_valid, 1);
        check("pre_rst_d", diff, 8'h07);
        #2;
        rst = 1'b1;
        #1;
        check("arst_v", out_valid, 0);
        check("arst_d", diff, 0);
        check("arst_b", borrow_out, 0);
        sbq.delete();
        acc_cnt = 0;
        emit_cnt = 0;
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("stale", out_valid, 0);
        end

        // random traffic on both sides
        tick();
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (LV + 6) tick();
        check("rnd_q", sbq.size(), 0);
        check("rnd_cnt", emit_cnt, acc_cnt);
        check("rnd_busy", acc_cnt > 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
